// File: rtl/mux_defs.sv
// Mode and state encodings for the channel scanner, shared by the
// design and its bench.
package mux_defs;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_SINGLE = 2'b01,
        MODE_CONT   = 2'b10,
        MODE_HOLD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SWEEP = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    function automatic logic is_sweep_mode(input mode_e m);
        return (m == MODE_SINGLE) || (m == MODE_CONT);
    endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational CHANNELS:1 selector over a flattened bus; an index with no
// matching channel yields zero.
module mux_n #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]          i_idx,
    output logic [WIDTH-1:0]          o_data
);

    always_comb begin
        o_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (i_idx == SEL_W'(k)) begin
                o_data = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// Channel scanner: direct selection or single/continuous sweeps of the input
// channels into a one-entry valid/ready output slot.
module mux_scan
    import mux_defs::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]          select,
    input  logic [1:0]                mode,
    input  logic                      start,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    output logic                      done,
    output logic                      busy,
    output logic                      err
);

    localparam logic [SEL_W-1:0] LAST_CHAN = SEL_W'(CHANNELS - 1);

    state_e             r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [WIDTH-1:0]   r_out_data;
    logic [SEL_W-1:0]   r_out_chan;
    logic               r_out_valid;
    logic               r_err;

    state_e             w_state_nxt;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic               w_capture;
    logic [SEL_W-1:0]   w_cap_idx;
    logic               w_set_err;
    logic               w_slot_free;
    logic               w_select_oob;
    logic [WIDTH-1:0]   w_mux_data;
    mode_e              w_mode;

    assign w_mode       = mode_e'(mode);
    assign w_slot_free  = !r_out_valid || out_ready;
    assign w_select_oob = 32'(select) >= 32'(CHANNELS);

    mux_n #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_mux (
        .i_data (data_in),
        .i_idx  (w_cap_idx),
        .o_data (w_mux_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_capture   = 1'b0;
        w_cap_idx   = r_ptr;
        w_set_err   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mode == MODE_DIRECT) begin
                    if (w_slot_free) begin
                        w_capture = 1'b1;
                        w_cap_idx = select;
                        w_set_err = w_select_oob;
                    end
                end else if (is_sweep_mode(w_mode) && start) begin
                    w_state_nxt = ST_SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                if (w_mode == MODE_DIRECT) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = '0;
                end else if (is_sweep_mode(w_mode) && w_slot_free) begin
                    w_capture = 1'b1;
                    // Last channel: single sweep finishes, continuous wraps.
                    if (r_ptr == LAST_CHAN) begin
                        w_ptr_nxt = '0;
                        if (w_mode == MODE_SINGLE) begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            if (w_capture) begin
                r_out_data  <= w_mux_data;
                r_out_chan  <= w_cap_idx;
                r_out_valid <= 1'b1;
            end else if (w_slot_free) begin
                r_out_valid <= 1'b0;
            end
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;
    assign err       = r_err;
    assign done      = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan with four 4-bit channels holding 1,2,3,4.
module tb_mux_scan;
    import mux_defs::*;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 3;

    logic                      clk = 1'b0;
    logic                      reset = 1'b0;
    logic [CHANNELS*WIDTH-1:0] data_in = {4'h4, 4'h3, 4'h2, 4'h1};
    logic [SEL_W-1:0]          select = '0;
    logic [1:0]                mode = 2'b11;
    logic                      start = 1'b0;
    logic                      out_ready = 1'b0;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      done;
    logic                      busy;
    logic                      err;

    int n_vec = 0;
    int n_bad = 0;

    mux_scan #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .select    (select),
        .mode      (mode),
        .start     (start),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_clear(input string tag);
        check({tag, ".data"},  32'(out_data),  32'h0);
        check({tag, ".chan"},  32'(out_chan),  32'h0);
        check({tag, ".valid"}, 32'(out_valid), 32'h0);
        check({tag, ".done"},  32'(done),      32'h0);
        check({tag, ".busy"},  32'(busy),      32'h0);
        check({tag, ".err"},   32'(err),       32'h0);
    endtask

    initial begin
        // Reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1 check_all_clear("rst0");
        tick();
        tick();
        reset = 1'b0;

        // Direct mode.
        mode = MODE_DIRECT; select = 3'd2; out_ready = 1'b1;
        tick();
        check("dir2.data",  32'(out_data),  32'h3);
        check("dir2.chan",  32'(out_chan),  32'h2);
        check("dir2.valid", 32'(out_valid), 32'h1);
        check("dir2.err",   32'(err),       32'h0);
        check("dir2.busy",  32'(busy),      32'h0);
        select = 3'd5;
        tick();
        check("dir5.data",  32'(out_data),  32'h0);
        check("dir5.chan",  32'(out_chan),  32'h5);
        check("dir5.err",   32'(err),       32'h1);
        select = 3'd1;
        tick();
        check("dir1.data",  32'(out_data),  32'h2);
        check("dir1.chan",  32'(out_chan),  32'h1);
        check("dir1.err",   32'(err),       32'h1);

        // Hold mode in IDLE: nothing captured, slot drains.
        mode = MODE_HOLD;
        tick();
        check("hold.valid", 32'(out_valid), 32'h0);
        check("hold.busy",  32'(busy),      32'h0);

        // Single sweep.
        mode = MODE_SINGLE; start = 1'b1;
        tick();
        start = 1'b0;
        check("ss.start.busy",  32'(busy),      32'h1);
        check("ss.start.valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("ss.data",  32'(out_data),  32'(i + 1));
            check("ss.chan",  32'(out_chan),  32'(i));
            check("ss.valid", 32'(out_valid), 32'h1);
            check("ss.done",  32'(done),      (i == 3) ? 32'h1 : 32'h0);
        end
        tick();
        check("ss.end.done",  32'(done),      32'h0);
        check("ss.end.busy",  32'(busy),      32'h0);
        check("ss.end.valid", 32'(out_valid), 32'h0);

        // Backpressure during a single sweep.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("bp.first", 32'(out_data), 32'h1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.stall.data",  32'(out_data),  32'h1);
            check("bp.stall.chan",  32'(out_chan),  32'h0);
            check("bp.stall.valid", 32'(out_valid), 32'h1);
        end
        out_ready = 1'b1;
        tick();
        check("bp.next.data", 32'(out_data), 32'h2);
        check("bp.next.chan", 32'(out_chan), 32'h1);
        tick();
        check("bp.ch2", 32'(out_data), 32'h3);
        tick();
        check("bp.ch3",   32'(out_data), 32'h4);
        check("bp.done",  32'(done),     32'h1);
        tick();
        check("bp.idle", 32'(busy), 32'h0);

        // Continuous sweep wraps, then abort via direct mode.
        mode = MODE_CONT; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("cont.chan", 32'(out_chan), 32'(i % 4));
            check("cont.data", 32'(out_data), 32'((i % 4) + 1));
            check("cont.done", 32'(done),     32'h0);
            check("cont.busy", 32'(busy),     32'h1);
        end
        mode = MODE_DIRECT; select = 3'd0;
        tick();
        check("abort.busy",  32'(busy),      32'h0);
        check("abort.done",  32'(done),      32'h0);
        check("abort.valid", 32'(out_valid), 32'h0);
        tick();
        check("abort.dir.data", 32'(out_data), 32'h1);
        check("abort.dir.done", 32'(done),     32'h0);

        // Reset mid-sweep at pointer 2, then restart from channel 0.
        mode = MODE_SINGLE; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("mid.pre.data", 32'(out_data), 32'h2);
        check("mid.pre.busy", 32'(busy),     32'h1);
        #2 reset = 1'b1;
        #1 check_all_clear("mid.rst");
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("mid.restart.busy", 32'(busy), 32'h1);
        tick();
        check("mid.restart.data",  32'(out_data),  32'h1);
        check("mid.restart.chan",  32'(out_chan),  32'h0);
        check("mid.restart.valid", 32'(out_valid), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter WIDTH, default 4: bit width of each data channel and of out_data.
REQ-002 Parameter CHANNELS, default 4: number of input channels, 2..2**SEL_W.
REQ-003 Parameter SEL_W, default 2: width of select, out_chan and the internal channel pointer.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 data_in  input  CHANNELS*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 select  input  SEL_W  channel index used in direct mode.
REQ-008 mode  input  2  00 direct, 01 single sweep, 10 continuous sweep, 11 hold.
REQ-009 start  input  1  begins a sweep when sampled high in IDLE with mode 01 or 10.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_data  output  WIDTH  registered selected channel value.
REQ-012 out_chan  output  SEL_W  index of the channel held in out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold a valid, not-yet-accepted sample.
REQ-014 done  output  1  one-cycle pulse at the end of a single sweep.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 err  output  1  sticky flag; set by a direct-mode select >= CHANNELS.

Function
REQ-017 Output slot is free in a cycle when out_valid==0 or out_ready==1; a capture happens only when the slot is free.
REQ-018 A capture loads out_data, out_chan and sets out_valid=1 at the next edge: latency one cycle.
REQ-019 While out_valid==1 and out_ready==0, out_data and out_chan remain stable.
REQ-020 If the slot is free and no capture occurs, out_valid clears at the edge.
REQ-021 States: IDLE, SWEEP, DONE.
REQ-022 IDLE, mode 00: capture channel select every free-slot cycle.
REQ-023 If select >= CHANNELS in direct mode, capture out_data=0 with out_chan=select and set err.
REQ-024 IDLE, mode 11: no capture.
REQ-025 IDLE, mode 01/10, start==1: go to SWEEP with pointer=0; no capture that cycle.
REQ-026 IDLE, mode 01/10, start==0: no capture.
REQ-027 SWEEP, mode 01/10: each free-slot cycle, capture channel pointer, then increment pointer.
REQ-028 SWEEP, capture of pointer==CHANNELS-1, mode 01: go to DONE.
REQ-029 SWEEP, capture of pointer==CHANNELS-1, mode 10: pointer wraps to 0 and state stays SWEEP.
REQ-030 SWEEP, mode 11: pause; no capture and pointer held.
REQ-031 SWEEP, mode 00: abort to IDLE, pointer=0, no done pulse.
REQ-032 DONE: done=1 for exactly that cycle, no capture, then IDLE.
REQ-033 start is ignored outside IDLE.
REQ-034 busy=1 in SWEEP and DONE.

Reset
REQ-035 reset high immediately forces, without waiting for clk: out_data=0, out_chan=0, out_valid=0, done=0, busy=0, err=0, state=IDLE, pointer=0.
REQ-036 A reset asserted mid-sweep discards the sweep and any pending sample.
REQ-037 Operation resumes on the first rising edge after reset deasserts.

Structure
REQ-038 Mode encodings and state encodings live in a shared definitions file mux_defs, included by design and bench.
REQ-039 One sub-module, mux_n: a combinational WIDTH-bit, CHANNELS:1 selector with index input, instantiated once and driven by select or pointer.

Verification
All scenarios use WIDTH=4, CHANNELS=4, and channels 0..3 = 4'h1, 4'h2, 4'h3, 4'h4.
REQ-040 Reset scenario: assert reset -> all outputs 0 before the next clk edge.
REQ-041 Direct scenario: mode 00, select=2, out_ready=1 -> next cycle out_data=4'h3, out_chan=2, out_valid=1; select=5 at SEL_W=3 -> out_data=0, err=1 and held.
REQ-042 Single-sweep scenario: mode 01, start pulse, out_ready=1 -> out_data 1,2,3,4 on consecutive cycles; done=1 one cycle after the last capture; busy=0 afterwards.
REQ-043 Backpressure scenario: out_ready=0 after the first capture -> out_data stays 4'h1 and out_valid stays 1; releasing out_ready -> next sample is 4'h2 with no channel skipped.
REQ-044 Continuous scenario: mode 10 for 6 transfers -> out_chan 0,1,2,3,0,1; then mode 00 -> IDLE with done never asserted.
REQ-045 Reset mid-operation scenario: reset during SWEEP at pointer=2 -> immediate clear; after release, a start restarts from channel 0.
